// File: rtl/alt_vipvfr131_common_frame_position_decoder_pkg.sv
// alt_vipvfr131_common_frame_position_decoder_pkg: packet types and decoder state encoding
package alt_vipvfr131_common_frame_position_decoder_pkg;
  localparam logic [3:0] PKT_VIDEO   = 4'h0;
  localparam logic [3:0] PKT_CONTROL = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_DISCARD, S_OVERRUN} state_t;
endpackage

// File: rtl/alt_vipvfr131_common_position_counter.sv
// alt_vipvfr131_common_position_counter: chained plane/x/y counter with wrap flags
module alt_vipvfr131_common_position_counter #(
  parameter int WORD_LENGTH  = 12,
  parameter int PLANES_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    restart,
  input  logic                    enable,
  input  logic [PLANES_WIDTH-1:0] plane_max,
  input  logic [WORD_LENGTH-1:0]  x_max,
  input  logic [WORD_LENGTH-1:0]  y_max,
  output logic [PLANES_WIDTH-1:0] plane,
  output logic [WORD_LENGTH-1:0]  x,
  output logic [WORD_LENGTH-1:0]  y,
  output logic                    plane_wrap,
  output logic                    x_wrap,
  output logic                    y_wrap
);
  assign plane_wrap = plane == plane_max;
  assign x_wrap     = x == x_max;
  assign y_wrap     = y == y_max;
  // each level advances only when every lower level wraps
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      plane <= '0;
      x     <= '0;
      y     <= '0;
    end else if (restart) begin
      plane <= '0;
      x     <= '0;
      y     <= '0;
    end else if (enable) begin
      plane <= plane_wrap ? '0 : plane + 1'b1;
      if (plane_wrap) begin
        x <= x_wrap ? '0 : x + 1'b1;
        if (x_wrap) y <= y_wrap ? '0 : y + 1'b1;
      end
    end
endmodule

// File: rtl/alt_vipvfr131_common_frame_position_decoder.sv
// alt_vipvfr131_common_frame_position_decoder: recovers plane/x/y of video beats and flags frame length errors
module alt_vipvfr131_common_frame_position_decoder
  import alt_vipvfr131_common_frame_position_decoder_pkg::*;
#(
  parameter int WORD_LENGTH       = 12,
  parameter int DATA_WIDTH        = 24,
  parameter int PLANES_WIDTH      = 2,
  parameter int BEATS_PER_PIXEL   = 1,
  parameter int FRAME_COUNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         din_valid,
  input  logic                         din_ready,
  input  logic                         din_sop,
  input  logic                         din_eop,
  input  logic [DATA_WIDTH-1:0]        din_data,
  input  logic [WORD_LENGTH-1:0]       width_m1,
  input  logic [WORD_LENGTH-1:0]       height_m1,
  output logic                         pix_valid,
  output logic [WORD_LENGTH-1:0]       pix_x,
  output logic [WORD_LENGTH-1:0]       pix_y,
  output logic [PLANES_WIDTH-1:0]      pix_plane,
  output logic                         pix_last,
  output logic                         frame_done,
  output logic                         short_frame,
  output logic                         long_frame,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         busy
);
  localparam logic [PLANES_WIDTH-1:0] PLANE_MAX = PLANES_WIDTH'(BEATS_PER_PIXEL - 1);
  state_t                   state, state_n;
  logic [WORD_LENGTH-1:0]   w_q, h_q, x, y;
  logic [PLANES_WIDTH-1:0]  plane;
  logic                     t, is_video, last, emit, done_n, short_n, long_n;
  logic                     plane_wrap, x_wrap, y_wrap;
  logic                     unused_data;
  assign unused_data = ^din_data;
  assign t        = din_valid && din_ready;
  assign is_video = din_data[3:0] == PKT_VIDEO;
  assign last     = plane_wrap && x_wrap && y_wrap;
  alt_vipvfr131_common_position_counter #(
    .WORD_LENGTH (WORD_LENGTH),
    .PLANES_WIDTH(PLANES_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (t && din_sop),
    .enable    (emit),
    .plane_max (PLANE_MAX),
    .x_max     (w_q),
    .y_max     (h_q),
    .plane     (plane),
    .x         (x),
    .y         (y),
    .plane_wrap(plane_wrap),
    .x_wrap    (x_wrap),
    .y_wrap    (y_wrap)
  );
  // a sop first closes the running packet, then is decoded as a fresh header
  always_comb begin
    state_n = state;
    emit    = 1'b0;
    done_n  = 1'b0;
    short_n = 1'b0;
    long_n  = 1'b0;
    if (t && din_sop) begin
      long_n  = state == S_OVERRUN;
      short_n = state == S_VIDEO || (is_video && din_eop && state != S_OVERRUN);
      state_n = din_eop ? S_IDLE : is_video ? S_VIDEO : S_DISCARD;
    end else if (t) begin
      emit    = state == S_VIDEO;
      done_n  = emit && last && din_eop;
      short_n = emit && !last && din_eop;
      long_n  = state == S_OVERRUN && din_eop;
      state_n = din_eop ? S_IDLE : (emit && last) ? S_OVERRUN : state;
    end
  end
  // geometry is frozen at the video header; all outputs are registered
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_plane   <= '0;
      pix_last    <= 1'b0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      long_frame  <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      state <= state_n;
      if (t && din_sop && is_video) begin
        w_q <= width_m1;
        h_q <= height_m1;
      end
      pix_valid   <= emit;
      pix_x       <= x;
      pix_y       <= y;
      pix_plane   <= plane;
      pix_last    <= emit && last;
      frame_done  <= done_n;
      short_frame <= short_n;
      long_frame  <= long_n;
      frame_count <= frame_count + FRAME_COUNT_WIDTH'(done_n || short_n || long_n);
      busy        <= state_n != S_IDLE;
    end
endmodule

// File: tb/tb_alt_vipvfr131_common_frame_position_decoder.sv
// tb_alt_vipvfr131_common_frame_position_decoder: directed checks of position decode and frame status
module tb_alt_vipvfr131_common_frame_position_decoder;
  logic        clk = 1'b0;
  logic        reset_n, din_valid, din_ready, din_sop, din_eop;
  logic [23:0] din_data;
  logic [11:0] width_m1, height_m1;
  logic        pv, pl, fd, sf, lf, bz, pv3, pl3, fd3, sf3, lf3, bz3;
  logic [11:0] px, py, px3, py3;
  logic [1:0]  pp, pp3;
  logic [7:0]  fc, fc3;
  int ncmp = 0, nerr = 0, npv;

  always #5 clk = ~clk;

  alt_vipvfr131_common_frame_position_decoder dut (
    .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din_ready(din_ready),
    .din_sop(din_sop), .din_eop(din_eop), .din_data(din_data),
    .width_m1(width_m1), .height_m1(height_m1),
    .pix_valid(pv), .pix_x(px), .pix_y(py), .pix_plane(pp), .pix_last(pl),
    .frame_done(fd), .short_frame(sf), .long_frame(lf), .frame_count(fc), .busy(bz)
  );

  alt_vipvfr131_common_frame_position_decoder #(.BEATS_PER_PIXEL(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din_ready(din_ready),
    .din_sop(din_sop), .din_eop(din_eop), .din_data(din_data),
    .width_m1(width_m1), .height_m1(height_m1),
    .pix_valid(pv3), .pix_x(px3), .pix_y(py3), .pix_plane(pp3), .pix_last(pl3),
    .frame_done(fd3), .short_frame(sf3), .long_frame(lf3), .frame_count(fc3), .busy(bz3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic s, input logic e, input logic [3:0] ty);
    din_valid = v;
    din_ready = r;
    din_sop   = s;
    din_eop   = e;
    din_data  = {20'h0, ty};
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    width_m1  = 12'd3;
    height_m1 = 12'd1;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 4'h0);
    chk("rst_pv", pv, 0);
    chk("rst_x", px, 0);
    chk("rst_y", py, 0);
    chk("rst_last", pl, 0);
    chk("rst_pulses", {fd, sf, lf}, 0);
    chk("rst_fc", fc, 0);
    chk("rst_busy", bz, 0);
    reset_n = 1'b1;

    drive(1, 1, 1, 0, 4'h0);
    chk("ex_sop_busy", bz, 1);
    chk("ex_sop_pv", pv, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, i == 7, 4'h0);
      chk("ex_pv", pv, 1);
      chk("ex_x", px, i % 4);
      chk("ex_y", py, i / 4);
      chk("ex_last", pl, i == 7);
      chk("ex_done", fd, i == 7);
    end
    chk("ex_fc", fc, 1);
    chk("ex_busy", bz, 0);
    drive(0, 1, 0, 0, 4'h0);
    chk("ex_done_pulse", fd, 0);

    drive(1, 1, 1, 0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, i == 4, 4'h0);
      chk("sh_last", pl, 0);
      chk("sh_short", sf, i == 4);
    end
    chk("sh_busy", bz, 0);
    chk("sh_fc", fc, 2);
    drive(0, 1, 0, 0, 4'h0);
    chk("sh_pulse", sf, 0);

    drive(1, 1, 1, 0, 4'h0);
    npv = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 0, i == 10, 4'h0);
      npv += int'(pv);
      chk("lg_long", lf, i == 10);
      chk("lg_done", fd, 0);
      chk("lg_busy", bz, i != 10);
    end
    chk("lg_npv", npv, 8);
    chk("lg_fc", fc, 3);

    width_m1  = 12'd1;
    height_m1 = 12'd0;
    drive(1, 1, 1, 0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, i == 5, 4'h0);
      chk("b3_pv", pv3, 1);
      chk("b3_plane", pp3, i % 3);
      chk("b3_x", px3, i / 3);
      chk("b3_y", py3, 0);
      chk("b3_last", pl3, i == 5);
      chk("b3_done", fd3, i == 5);
    end
    chk("b3_single_long", lf, 1);
    chk("b3_single_fc", fc, 4);
    width_m1  = 12'd3;
    height_m1 = 12'd1;

    npv = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1, k % 2 == 0, k == 0, k == 18, k == 0 ? 4'hF : 4'h0);
      npv += int'(pv);
      chk("ct_busy", bz, k < 18);
    end
    chk("ct_npv", npv, 0);
    chk("ct_fc", fc, 4);
    drive(1, 1, 1, 0, 4'h0);
    width_m1  = 12'd7;
    height_m1 = 12'd5;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, i == 7, 4'h0);
      chk("cv_x", px, i % 4);
      chk("cv_y", py, i / 4);
      chk("cv_last", pl, i == 7);
    end
    chk("cv_done", fd, 1);
    chk("cv_fc", fc, 5);
    width_m1  = 12'd3;
    height_m1 = 12'd1;

    drive(1, 1, 1, 0, 4'h0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 4'h0);
    drive(1, 1, 1, 0, 4'h0);
    chk("me_short", sf, 1);
    chk("me_fc", fc, 6);
    chk("me_pv", pv, 0);
    drive(1, 1, 0, 0, 4'h0);
    chk("me_pv1", pv, 1);
    chk("me_x0", px, 0);
    chk("me_y0", py, 0);
    drive(1, 1, 0, 0, 4'h0);
    chk("me_x1", px, 1);

    reset_n = 1'b0;
    #1;
    chk("mr_pv", pv, 0);
    chk("mr_xy", {px, py}, 0);
    chk("mr_plane", pp, 0);
    chk("mr_last", pl, 0);
    chk("mr_pulses", {fd, sf, lf}, 0);
    chk("mr_fc", fc, 0);
    chk("mr_busy", bz, 0);
    drive(1, 1, 0, 0, 4'h0);
    reset_n = 1'b1;
    drive(1, 1, 0, 1, 4'h0);
    chk("mr_after_pv", pv, 0);
    chk("mr_after_pulses", {fd, sf, lf}, 0);
    chk("mr_after_busy", bz, 0);
    chk("mr_after_fc", fc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/alt_vipvfr131_common_frame_position_decoder.md
# alt_vipvfr131_common_frame_position_decoder

Receive-side counterpart to the frame reader's pixel/line counters. It observes an Avalon-ST Video stream and recovers the (plane, x, y) position of every accepted video beat against a configured frame geometry. It reports frame completion and short/long frame errors. It sits on the input of capture and check paths, alongside the packet-sink logic, and never stalls the stream.

## Interface
Parameters:
- WORD_LENGTH, 12: width of x/y counters and geometry inputs.
- DATA_WIDTH, 24: stream data width; must be ≥ 4.
- PLANES_WIDTH, 2: width of the plane counter.
- BEATS_PER_PIXEL, 1: beats (colour planes in sequence) per pixel.
- FRAME_COUNT_WIDTH, 8: width of the frame counter.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous, active-low reset.
- din_valid, in, 1: stream valid.
- din_ready, in, 1: ready driven by the downstream sink; observed only.
- din_sop, in, 1: start of packet.
- din_eop, in, 1: end of packet.
- din_data, in, DATA_WIDTH: stream data; bits [3:0] on the sop beat give the packet type.
- width_m1, in, WORD_LENGTH: frame width − 1.
- height_m1, in, WORD_LENGTH: frame height − 1.
- pix_valid, out, 1: registered strobe, one per accepted in-frame video beat.
- pix_x, out, WORD_LENGTH: pixel column of that beat.
- pix_y, out, WORD_LENGTH: line of that beat.
- pix_plane, out, PLANES_WIDTH: plane index within the pixel.
- pix_last, out, 1: the beat is the final expected beat of the frame.
- frame_done, out, 1: 1-cycle pulse; frame ended with exactly the expected beat count.
- short_frame, out, 1: 1-cycle pulse; frame terminated early.
- long_frame, out, 1: 1-cycle pulse; frame had surplus beats.
- frame_count, out, FRAME_COUNT_WIDTH: number of video packets terminated; wraps.
- busy, out, 1: state ≠ IDLE.

## Operation
- A transfer is din_valid && din_ready. Nothing advances without a transfer.
- **IDLE:**
  - Non-sop beats are ignored.
  - A sop beat with type 0 latches width_m1/height_m1, clears plane/x/y, and moves to VIDEO.
  - A sop beat with any other type moves to DISCARD.
  - sop and eop on the same beat returns to IDLE. For type 0 this raises short_frame (header only, zero pixels).
- **VIDEO:** each non-sop transfer emits pix_* with the current position, then advances.
  - plane wraps at BEATS_PER_PIXEL − 1.
  - On plane wrap, x increments; x wraps at the latched width.
  - On x wrap, y increments.
  - The beat at (BEATS_PER_PIXEL−1, w_m1, h_m1) sets pix_last.
  - If that last beat also carries eop: frame_done, return to IDLE.
  - If the last beat has no eop: move to OVERRUN.
  - eop before the last beat: short_frame, IDLE.
- **OVERRUN:** beats are not emitted on pix_*. On eop: long_frame, IDLE.
- **DISCARD:** beats are ignored. On eop: IDLE.
- **sop in VIDEO/OVERRUN/DISCARD:**
  - A terminated VIDEO raises short_frame; OVERRUN raises long_frame; DISCARD raises nothing.
  - The sop beat is then decoded as in IDLE, in the same cycle.
- frame_count increments by one on every frame_done, short_frame or long_frame pulse.
- Geometry inputs are sampled only at a video sop. Changes mid-frame have no effect.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - pix_valid, pix_x, pix_y, pix_plane, pix_last: 0.
  - frame_done, short_frame, long_frame: 0.
  - frame_count: 0; busy: 0.
- Latency:
  - All outputs are registered.
  - pix_* and the status pulses appear on the cycle after the transfer that causes them.
  - busy reflects the registered state.
- Throughput: one transfer per cycle, no bubbles.
- A mid-packet reset discards the frame silently, with no pulse. Following beats are ignored until the next sop.
- At most one of frame_done, short_frame, long_frame is asserted in any cycle.

## Structure
- Shared package holds:
  - packet-type constants: VIDEO=4'h0, CONTROL=4'hF;
  - state encoding: IDLE, VIDEO, DISCARD, OVERRUN.
- The natural sub-module is alt_vipvfr131_common_position_counter, a chained plane/x/y counter with wrap outputs.
  - Instantiated once.
  - Per-level inputs: enable, restart, max value.

## Test plan
- **Exact frame:** width_m1=3, height_m1=1, BEATS_PER_PIXEL=1; video sop, then 8 beats with eop on the 8th.
  - pix_x 0..3 on y=0, then 0..3 on y=1.
  - pix_last on the 8th beat; frame_done the cycle after it; frame_count=1.
- **Short frame:** same geometry, eop on the 5th beat → short_frame once, no pix_last, state IDLE.
- **Long frame:** same geometry, 11 beats → pix_valid 8 times, long_frame after the 11th beat's eop.
- **BEATS_PER_PIXEL=3, 2×1 frame:**
  - pix_plane 0,1,2,0,1,2 against x 0,0,0,1,1,1;
  - frame_done after the 6th beat.
- **Control packet with ready gaps:** type 0xF packet of 10 beats, with din_ready low on alternate cycles, then a video frame → no pix_valid during the control packet; the video frame decodes correctly.
- **Missing eop and reset:**
  - A video sop arriving mid-frame → short_frame, and the new frame starts at x=0, y=0.
  - reset_n low mid-frame → all outputs 0, no pulse.
